// File: rtl/heepstor_pkg.sv
// rtl/heepstor_pkg.sv - shared types and constants for the HEEPstor systolic-array OBI bridge
//
// Contents:
//   SA_*_OFFS           byte offsets of the bridge registers (decoded on addr[4:2])
//   SA_CTRL_*_BIT       bit positions inside the CTRL register
//   obi_req_t           OBI request  {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   obi_resp_t          OBI response {gnt, rvalid, rdata[31:0]}
//   sa_offs_hit()       word-offset match that ignores the byte lane and upper address bits

package heepstor_pkg;

    localparam logic [4:0] SA_CTRL_OFFS   = 5'h00;
    localparam logic [4:0] SA_STATUS_OFFS = 5'h04;
    localparam logic [4:0] SA_WEIGHT_OFFS = 5'h08;
    localparam logic [4:0] SA_INPUT_OFFS  = 5'h0C;
    localparam logic [4:0] SA_OUTPUT_OFFS = 5'h10;

    localparam int SA_CTRL_START_BIT = 0;
    localparam int SA_CTRL_CLEAR_BIT = 1;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Only addr[4:2] selects a register; everything above aliases.
    function automatic logic sa_offs_hit(input logic [31:0] addr, input logic [4:0] offs);
        return addr[4:2] == offs[4:2];
    endfunction

endpackage

// File: rtl/heepstor_sync_fifo.sv
// rtl/heepstor_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                drops all entries at the next edge (wins over push/pop)
//   push_i, data_i         write side; a push while full is ignored
//   pop_i, data_o          read side; data_o is the head entry, valid while !empty_o
//   full_o, empty_o        occupancy flags
//   count_o                number of stored entries

module heepstor_sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rptr];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem[wptr] <= data_i;
        end
    end

endmodule

// File: rtl/heepstor_sa_obi_bridge.sv
// rtl/heepstor_sa_obi_bridge.sv - OBI slave front end feeding the HEEPstor systolic array
//
// Ports:
//   clk_i, rst_ni                               clock, asynchronous active-low reset
//   req_i / resp_o                              OBI slave request / response
//   weight_valid_o/weight_ready_i/weight_data_o weight stream to the array
//   input_valid_o/input_ready_i/input_data_o    input stream to the array
//   output_valid_i/output_ready_o/output_data_i result stream from the array
//   start_o                                     one-cycle start pulse
//   busy_i                                      array busy, reported in STATUS bit 0

module heepstor_sa_obi_bridge
    import heepstor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    req_i,
    output obi_resp_t   resp_o,
    output logic        weight_valid_o,
    input  logic        weight_ready_i,
    output logic [31:0] weight_data_o,
    output logic        input_valid_o,
    input  logic        input_ready_i,
    output logic [31:0] input_data_o,
    input  logic        output_valid_i,
    output logic        output_ready_o,
    input  logic [31:0] output_data_i,
    output logic        start_o,
    input  logic        busy_i
);

    logic             sel_ctrl;
    logic             sel_status;
    logic             sel_weight;
    logic             sel_input;
    logic             sel_output;
    logic             wr_weight;
    logic             wr_input;
    logic             rd_output;
    logic             stall;
    logic             gnt;
    logic             ctrl_act;
    logic             fifo_clear;
    logic             start_d;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             i_full;
    logic             i_empty;
    logic [CNT_W-1:0] i_count;
    logic             o_full;
    logic             o_empty;
    logic [CNT_W-1:0] o_count;
    logic [31:0]      o_head;

    logic [31:0]      status_word;
    logic [31:0]      rdata_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic             start_q;
    logic             unused_bits;

    assign sel_ctrl   = sa_offs_hit(req_i.addr, SA_CTRL_OFFS);
    assign sel_status = sa_offs_hit(req_i.addr, SA_STATUS_OFFS);
    assign sel_weight = sa_offs_hit(req_i.addr, SA_WEIGHT_OFFS);
    assign sel_input  = sa_offs_hit(req_i.addr, SA_INPUT_OFFS);
    assign sel_output = sa_offs_hit(req_i.addr, SA_OUTPUT_OFFS);

    assign wr_weight = req_i.req & req_i.we & sel_weight;
    assign wr_input  = req_i.req & req_i.we & sel_input;
    assign rd_output = req_i.req & ~req_i.we & sel_output;

    // Stalls look only at registered FIFO state, so a same-cycle stream pop
    // cannot release a blocked write and no ready/valid input reaches resp_o.
    assign stall = (wr_weight & w_full) | (wr_input & i_full) | (rd_output & o_empty);
    assign gnt   = req_i.req & ~stall;

    assign ctrl_act   = gnt & req_i.we & sel_ctrl & req_i.be[0];
    assign fifo_clear = ctrl_act & req_i.wdata[SA_CTRL_CLEAR_BIT];
    assign start_d    = ctrl_act & req_i.wdata[SA_CTRL_START_BIT];

    heepstor_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_weight_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (fifo_clear),
        .push_i  (gnt & wr_weight),
        .data_i  (req_i.wdata),
        .pop_i   (weight_ready_i),
        .data_o  (weight_data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    heepstor_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_input_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (fifo_clear),
        .push_i  (gnt & wr_input),
        .data_i  (req_i.wdata),
        .pop_i   (input_ready_i),
        .data_o  (input_data_o),
        .full_o  (i_full),
        .empty_o (i_empty),
        .count_o (i_count)
    );

    heepstor_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_output_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (fifo_clear),
        .push_i  (output_valid_i),
        .data_i  (output_data_i),
        .pop_i   (gnt & rd_output),
        .data_o  (o_head),
        .full_o  (o_full),
        .empty_o (o_empty),
        .count_o (o_count)
    );

    assign weight_valid_o = ~w_empty;
    assign input_valid_o  = ~i_empty;
    assign output_ready_o = ~o_full;

    assign status_word = {20'h0, 4'(o_count), 4'h0, o_empty, i_full, w_full, busy_i};

    // Writes and reads of CTRL or unmapped offsets return zero.
    always_comb begin
        rdata_d = 32'h0;
        if (gnt && !req_i.we) begin
            if (sel_status) begin
                rdata_d = status_word;
            end else if (sel_output) begin
                rdata_d = o_head;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            start_q  <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= rdata_d;
            start_q  <= start_d;
        end
    end

    assign resp_o.gnt    = gnt;
    assign resp_o.rvalid = rvalid_q;
    assign resp_o.rdata  = rdata_q;
    assign start_o       = start_q;

    assign unused_bits = ^{req_i.be[3:1], req_i.addr[31:5], req_i.addr[1:0], w_count, i_count};

endmodule

// File: tb/tb_heepstor_sa_obi_bridge.sv
// tb/tb_heepstor_sa_obi_bridge.sv - self-checking bench for heepstor_sa_obi_bridge

module tb_heepstor_sa_obi_bridge;
    import heepstor_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    obi_req_t    req;
    obi_resp_t   resp;
    logic        weight_valid;
    logic        weight_ready;
    logic [31:0] weight_data;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] output_data;
    logic        start;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain queues standing in for the three FIFOs.
    logic [31:0] mq_w[$];
    logic [31:0] mq_i[$];
    logic [31:0] mq_o[$];
    logic        exp_gnt;
    logic        obs_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_start;

    heepstor_sa_obi_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .resp_o         (resp),
        .weight_valid_o (weight_valid),
        .weight_ready_i (weight_ready),
        .weight_data_o  (weight_data),
        .input_valid_o  (input_valid),
        .input_ready_i  (input_ready),
        .input_data_o   (input_data),
        .output_valid_i (output_valid),
        .output_ready_o (output_ready),
        .output_data_i  (output_data),
        .start_o        (start),
        .busy_i         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_bus(input logic r, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        req.req   = r;
        req.we    = we;
        req.addr  = addr;
        req.wdata = wdata;
        req.be    = be;
    endtask

    task automatic model_reset();
        mq_w.delete();
        mq_i.delete();
        mq_o.delete();
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        m_start  = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; samples gnt, predicts, advances one clock.
    task automatic tick();
        logic [2:0]  idx;
        logic [31:0] rv;
        logic [31:0] wd;
        logic [31:0] o_word;
        logic        clr, st, w_pop, i_pop, o_push, bus_w, bus_i, bus_o;
        #3;
        obs_gnt = resp.gnt;
        idx = req.addr[4:2];
        exp_gnt = req.req;
        if (req.we && idx == 3'd2 && mq_w.size() == DEPTH) exp_gnt = 1'b0;
        if (req.we && idx == 3'd3 && mq_i.size() == DEPTH) exp_gnt = 1'b0;
        if (!req.we && idx == 3'd4 && mq_o.size() == 0) exp_gnt = 1'b0;
        rv = 32'h0;
        if (exp_gnt && !req.we) begin
            if (idx == 3'd1)
                rv = {20'h0, 4'(mq_o.size()), 4'h0, (mq_o.size() == 0),
                      (mq_i.size() == DEPTH), (mq_w.size() == DEPTH), busy};
            else if (idx == 3'd4)
                rv = mq_o[0];
        end
        clr    = exp_gnt && req.we && idx == 3'd0 && req.be[0] && req.wdata[1];
        st     = exp_gnt && req.we && idx == 3'd0 && req.be[0] && req.wdata[0];
        w_pop  = weight_ready && mq_w.size() > 0;
        i_pop  = input_ready && mq_i.size() > 0;
        o_push = output_valid && mq_o.size() < DEPTH;
        o_word = output_data;
        bus_w  = exp_gnt && req.we && idx == 3'd2;
        bus_i  = exp_gnt && req.we && idx == 3'd3;
        bus_o  = exp_gnt && !req.we && idx == 3'd4;
        wd     = req.wdata;
        @(posedge clk);
        #1;
        m_rvalid = exp_gnt;
        m_rdata  = rv;
        m_start  = st;
        if (clr) begin
            mq_w.delete();
            mq_i.delete();
            mq_o.delete();
        end else begin
            if (w_pop) void'(mq_w.pop_front());
            if (bus_w) mq_w.push_back(wd);
            if (i_pop) void'(mq_i.pop_front());
            if (bus_i) mq_i.push_back(wd);
            if (bus_o) void'(mq_o.pop_front());
            if (o_push) mq_o.push_back(o_word);
        end
    endtask

    task automatic test_reset();
        n_tests++; if (resp.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", resp.rvalid); end
        n_tests++; if (resp.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", resp.rdata); end
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
        n_tests++; if (weight_valid !== 1'b0) begin n_fail++; $display("FAIL reset_weight_valid: got %b expected 0", weight_valid); end
        n_tests++; if (input_valid !== 1'b0) begin n_fail++; $display("FAIL reset_input_valid: got %b expected 0", input_valid); end
        n_tests++; if (output_ready !== 1'b1) begin n_fail++; $display("FAIL reset_output_ready: got %b expected 1", output_ready); end
    endtask

    task automatic test_weight_write();
        weight_ready = 1'b0;
        set_bus(1'b1, 1'b1, 32'h08, 32'hA5A5_0001, 4'h0);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (obs_gnt !== 1'b1) begin n_fail++; $display("FAIL weight_gnt: got %b expected 1", obs_gnt); end
        n_tests++; if (resp.rvalid !== 1'b1) begin n_fail++; $display("FAIL weight_rvalid: got %b expected 1", resp.rvalid); end
        n_tests++; if (resp.rdata !== 32'h0) begin n_fail++; $display("FAIL weight_rdata: got %h expected 0", resp.rdata); end
        n_tests++; if (weight_valid !== 1'b1) begin n_fail++; $display("FAIL weight_valid: got %b expected 1", weight_valid); end
        n_tests++; if (weight_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL weight_data: got %h expected a5a50001", weight_data); end
        weight_ready = 1'b1;
        tick();
        weight_ready = 1'b0;
        n_tests++; if (weight_valid !== 1'b0) begin n_fail++; $display("FAIL weight_drained: got %b expected 0", weight_valid); end
    endtask

    task automatic test_input_full();
        logic [31:0] words [5];
        int k;
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        input_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_bus(1'b1, 1'b1, 32'h0C, words[i], 4'h0);
            tick();
            n_tests++; if (obs_gnt !== 1'b1) begin n_fail++; $display("FAIL input_fill_gnt[%0d]: got %b expected 1", i, obs_gnt); end
        end
        set_bus(1'b1, 1'b1, 32'h0C, words[4], 4'h0);
        tick();
        n_tests++; if (obs_gnt !== 1'b0) begin n_fail++; $display("FAIL input_full_stall: got %b expected 0", obs_gnt); end
        input_ready = 1'b1;
        tick();
        n_tests++; if (obs_gnt !== 1'b0) begin n_fail++; $display("FAIL input_pop_no_unblock: got %b expected 0", obs_gnt); end
        input_ready = 1'b0;
        tick();
        n_tests++; if (obs_gnt !== 1'b1) begin n_fail++; $display("FAIL input_fifth_gnt: got %b expected 1", obs_gnt); end
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        input_ready = 1'b1;
        k = 1;
        for (int c = 0; c < 8; c++) begin
            if (input_valid === 1'b1) begin
                n_tests++; if (input_data !== words[k]) begin n_fail++; $display("FAIL input_order[%0d]: got %h expected %h", k, input_data, words[k]); end
                k++;
            end
            tick();
        end
        input_ready = 1'b0;
        n_tests++; if (k !== 5) begin n_fail++; $display("FAIL input_drain_count: got %0d expected 5", k); end
    endtask

    task automatic test_output_read();
        set_bus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        n_tests++; if (obs_gnt !== 1'b0) begin n_fail++; $display("FAIL output_empty_stall: got %b expected 0", obs_gnt); end
        output_valid = 1'b1;
        output_data  = 32'h0000_1234;
        tick();
        n_tests++; if (obs_gnt !== 1'b0) begin n_fail++; $display("FAIL output_push_cycle_gnt: got %b expected 0", obs_gnt); end
        output_valid = 1'b0;
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (obs_gnt !== 1'b1) begin n_fail++; $display("FAIL output_read_gnt: got %b expected 1", obs_gnt); end
        n_tests++; if (resp.rvalid !== 1'b1) begin n_fail++; $display("FAIL output_read_rvalid: got %b expected 1", resp.rvalid); end
        n_tests++; if (resp.rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL output_read_rdata: got %h expected 00001234", resp.rdata); end
    endtask

    task automatic test_ctrl_clear_start();
        weight_ready = 1'b0;
        input_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_bus(1'b1, 1'b1, (i < 2) ? 32'h08 : 32'h0C, $urandom, 4'h0);
            output_valid = (i < 2);
            output_data  = $urandom;
            tick();
        end
        output_valid = 1'b0;
        set_bus(1'b1, 1'b1, 32'h00, 32'h3, 4'hF);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (obs_gnt !== 1'b1) begin n_fail++; $display("FAIL ctrl_gnt: got %b expected 1", obs_gnt); end
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL ctrl_start_high: got %b expected 1", start); end
        n_tests++; if (weight_valid !== 1'b0 || input_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_clear_valids: got %b%b expected 00", weight_valid, input_valid); end
        n_tests++; if (output_ready !== 1'b1) begin n_fail++; $display("FAIL ctrl_clear_output_ready: got %b expected 1", output_ready); end
        tick();
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL ctrl_start_one_cycle: got %b expected 0", start); end
        set_bus(1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        tick();
        n_tests++; if (resp.rdata !== 32'h0000_0008) begin n_fail++; $display("FAIL ctrl_status_idle: got %h expected 00000008", resp.rdata); end
        busy = 1'b1;
        tick();
        busy = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (resp.rdata !== 32'h0000_0009) begin n_fail++; $display("FAIL ctrl_status_busy: got %h expected 00000009", resp.rdata); end
    endtask

    task automatic test_unmapped();
        logic [31:0] status_before;
        set_bus(1'b1, 1'b1, 32'h14, $urandom, 4'hF);
        tick();
        n_tests++; if (obs_gnt !== 1'b1 || resp.rvalid !== 1'b1) begin n_fail++; $display("FAIL unmapped_write: got gnt %b rvalid %b expected 1 1", obs_gnt, resp.rvalid); end
        set_bus(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        tick();
        n_tests++; if (obs_gnt !== 1'b1 || resp.rvalid !== 1'b1) begin n_fail++; $display("FAIL unmapped_read: got gnt %b rvalid %b expected 1 1", obs_gnt, resp.rvalid); end
        n_tests++; if (resp.rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata: got %h expected 0", resp.rdata); end
        status_before = {20'h0, 4'(mq_o.size()), 4'h0, (mq_o.size() == 0), (mq_i.size() == DEPTH), (mq_w.size() == DEPTH), 1'b0};
        set_bus(1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (resp.rdata !== status_before) begin n_fail++; $display("FAIL unmapped_no_change: got %h expected %h", resp.rdata, status_before); end
    endtask

    task automatic test_reset_mid();
        set_bus(1'b1, 1'b1, 32'h08, $urandom, 4'h0);
        output_valid = 1'b1;
        output_data  = $urandom;
        tick();
        output_valid = 1'b0;
        set_bus(1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        #3;
        n_tests++; if (resp.gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", resp.gnt); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (resp.rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b expected 0", resp.rvalid); end
        n_tests++; if (weight_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_weight_valid: got %b expected 0", weight_valid); end
        n_tests++; if (output_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_output_ready: got %b expected 1", output_ready); end
        rst_n = 1'b1;
        set_bus(1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_tests++; if (resp.rdata !== 32'h0000_0008) begin n_fail++; $display("FAIL rstmid_status: got %h expected 00000008", resp.rdata); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] wdata;
        for (int c = 0; c < 400; c++) begin
            addr = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            wdata = $urandom;
            if (addr[4:2] == 3'd0 && $urandom_range(0, 3) != 0) wdata[1] = 1'b0;
            set_bus($urandom_range(0, 3) != 0, $urandom_range(0, 1), addr, wdata, 4'($urandom));
            weight_ready = ($urandom_range(0, 2) == 0);
            input_ready  = ($urandom_range(0, 2) == 0);
            output_valid = $urandom_range(0, 1);
            output_data  = $urandom;
            busy         = $urandom_range(0, 1);
            tick();
            n_tests++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, obs_gnt, exp_gnt); end
            n_tests++; if (resp.rvalid !== m_rvalid) begin n_fail++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", c, resp.rvalid, m_rvalid); end
            if (m_rvalid) begin
                n_tests++; if (resp.rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, resp.rdata, m_rdata); end
            end
            n_tests++; if (start !== m_start) begin n_fail++; $display("FAIL rand_start[%0d]: got %b expected %b", c, start, m_start); end
            n_tests++; if (weight_valid !== (mq_w.size() > 0)) begin n_fail++; $display("FAIL rand_weight_valid[%0d]: got %b expected %b", c, weight_valid, mq_w.size() > 0); end
            n_tests++; if (input_valid !== (mq_i.size() > 0)) begin n_fail++; $display("FAIL rand_input_valid[%0d]: got %b expected %b", c, input_valid, mq_i.size() > 0); end
            n_tests++; if (output_ready !== (mq_o.size() < DEPTH)) begin n_fail++; $display("FAIL rand_output_ready[%0d]: got %b expected %b", c, output_ready, mq_o.size() < DEPTH); end
            if (mq_w.size() > 0) begin
                n_tests++; if (weight_data !== mq_w[0]) begin n_fail++; $display("FAIL rand_weight_data[%0d]: got %h expected %h", c, weight_data, mq_w[0]); end
            end
            if (mq_i.size() > 0) begin
                n_tests++; if (input_data !== mq_i[0]) begin n_fail++; $display("FAIL rand_input_data[%0d]: got %h expected %h", c, input_data, mq_i[0]); end
            end
        end
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        weight_ready = 1'b0;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        busy         = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        weight_ready = 1'b0;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        output_data  = 32'h0;
        busy         = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_weight_write();
        test_input_full();
        test_output_read();
        test_ctrl_clear_start();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
